// File: rtl/data_cache_pkg.sv
// Shared encodings for the L1 data cache: controller states and memory write-enable levels.
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    localparam logic MEM_WE_READ  = 1'b0;
    localparam logic MEM_WE_WRITE = 1'b1;

endpackage

// File: rtl/data_cache_store.sv
// Line storage for the direct-mapped cache: LINES x {valid, tag, data}.
// Asynchronous read port, one synchronous write port; reset clears only the valid bits.
module cache_store #(
    parameter int LINES   = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data contents survive reset; only valid decides whether they are usable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr[wr_index]  <= wr_tag;
            data_arr[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_arr[rd_index];
    assign rd_data  = data_arr[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache (one word per line)
// with a req/ack main-memory port and a stall output to the hazard unit.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = 30 - INDEX_W;

    state_t state, next;

    logic [INDEX_W-1:0] cpu_index, lat_index, rd_index;
    logic [TAG_W-1:0]   cpu_tag, lat_tag, rd_tag, cmp_tag;
    logic               rd_valid, hit, wr_en;
    logic [31:0]        rd_data, wr_data;
    logic               unused_bits;

    assign unused_bits = ^cpu_addr[1:0];

    // The registered mem_addr/mem_wdata double as the latched request.
    assign cpu_index = cpu_addr[INDEX_W+1:2];
    assign cpu_tag   = cpu_addr[31:INDEX_W+2];
    assign lat_index = mem_addr[INDEX_W+1:2];
    assign lat_tag   = mem_addr[31:INDEX_W+2];

    assign rd_index = (state == IDLE) ? cpu_index : lat_index;
    assign cmp_tag  = (state == IDLE) ? cpu_tag : lat_tag;
    assign hit      = rd_valid && (rd_tag == cmp_tag);

    cache_store #(
        .LINES  (LINES),
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .rd_index(rd_index),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_index(lat_index),
        .wr_tag  (lat_tag),
        .wr_data (wr_data)
    );

    always_comb begin
        next      = state;
        stall     = 1'b0;
        cpu_rdata = '0;
        wr_en     = 1'b0;
        wr_data   = mem_rdata;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    next  = WR_THRU;
                    stall = 1'b1;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = rd_data;
                    end else begin
                        next  = RD_MISS;
                        stall = 1'b1;
                    end
                end
            end
            RD_MISS: begin
                if (mem_ack) begin
                    cpu_rdata = mem_rdata;
                    wr_en     = 1'b1;
                    next      = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            WR_THRU: begin
                wr_data = mem_wdata;
                if (mem_ack) begin
                    wr_en = hit;
                    next  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
        // Nothing may hold the pipeline while reset is asserted.
        if (!reset) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= MEM_WE_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= next;
            if (state == IDLE && next != IDLE) begin
                mem_req  <= 1'b1;
                mem_we   <= (next == WR_THRU) ? MEM_WE_WRITE : MEM_WE_READ;
                mem_addr <= {cpu_addr[31:2], 2'b00};
                if (next == WR_THRU) mem_wdata <= cpu_wdata;
            end else if (state != IDLE && next == IDLE) begin
                mem_req <= 1'b0;
                mem_we  <= MEM_WE_READ;
            end
        end
    end

endmodule
